// File: rtl/ctl_seq_pkg.sv
// Shared types and encodings for the control sequencer.
package ctl_seq_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDispatch,
      StExec,
      StLoad,
      StLoadWb,
      StStore,
      StStoreDone,
      StHalted,
      StResuming
   } state_t;

   typedef enum logic [2:0] {
      OpAlu,
      OpNowb,
      OpLoad,
      OpStore,
      OpCsr
   } op_class_t;

   localparam logic [1:0] RD_ALU = 2'd0;
   localparam logic [1:0] RD_MEM = 2'd1;
   localparam logic [1:0] RD_CSR = 2'd2;

   localparam logic ADDR_PC  = 1'b0;
   localparam logic ADDR_ALU = 1'b1;

   function automatic state_t map_class(op_class_t oc);
      case (oc)
         OpLoad:  return StLoad;
         OpStore: return StStore;
         default: return StExec;
      endcase
   endfunction

endpackage

// File: rtl/ctl_seq_if.sv
// Bus request/handshake bundle between the sequencer and the bus adapter.
interface ctl_seq_if #(
   parameter int unsigned BW = 1
);
   logic          mem_read;
   logic          mem_write;
   logic          addr_sel;
   logic [BW-1:0] beat;
   logic          mem_complete;

   modport master (
      output mem_read,
      output mem_write,
      output addr_sel,
      output beat,
      input  mem_complete
   );

   modport slave (
      input  mem_read,
      input  mem_write,
      input  addr_sel,
      input  beat,
      output mem_complete
   );
endinterface

// File: rtl/ctl_seq_beatcnt.sv
// Beat index within a multi-beat access plus the per-beat wait-state counter.
module ctl_seq_beatcnt #(
   parameter int unsigned BEATS   = 1,
   parameter int unsigned TIMEOUT = 0,
   parameter int unsigned BW      = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          active,
   input  logic          done,
   input  logic          clr,
   input  logic          state_chg,
   output logic [BW-1:0] beat,
   output logic          last_beat,
   output logic          timeout_hit
);
   localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

   logic [BW-1:0] beat_q, beat_d;
   logic [WW-1:0] wait_q, wait_d;

   assign beat        = beat_q;
   assign last_beat   = (beat_q == BW'(BEATS - 1));
   assign timeout_hit = (TIMEOUT != 0) && active && !done && (wait_q == WAIT_MAX);

   always_comb begin
      beat_d = beat_q;
      if (clr) begin
         beat_d = '0;
      end else if (active && done) begin
         beat_d = last_beat ? '0 : beat_q + BW'(1);
      end
   end

   // Saturates at WAIT_MAX; the timeout abort clears it the same cycle anyway.
   always_comb begin
      wait_d = wait_q;
      if (clr || done || state_chg || !active) begin
         wait_d = '0;
      end else if ((TIMEOUT != 0) && (wait_q != WAIT_MAX)) begin
         wait_d = wait_q + WW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q <= '0;
         wait_q <= '0;
      end else begin
         beat_q <= beat_d;
         wait_q <= wait_d;
      end
   end

endmodule

// File: rtl/control_seq.sv
// Microcode sequencer: multi-beat fetch/load/store, wait-state timeout and
// debug halt/single-step. All outputs are combinational from state and inputs.
module control_seq
   import ctl_seq_pkg::*;
#(
   parameter int unsigned BEATS   = 1,
   parameter int unsigned TIMEOUT = 0,
   parameter int unsigned BW      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic       clk,
   input  logic       rst_n,
   ctl_seq_if.master  bus,
   input  op_class_t  op_class,
   input  logic       exception,
   input  logic       debug_req,
   input  logic       step,
   input  logic       trigger,
   output logic       write_ir,
   output logic       write_rd,
   output logic [1:0] rd_sel,
   output logic       write_csr,
   output logic       write_pc_ne,
   output logic       write_pc_ex,
   output logic       halted,
   output logic       mem_fault
);
   state_t        state_q, state_d, cur;
   logic          step_pend_q, step_pend_d;
   logic          active, clr, state_chg, last_beat, timeout_hit;
   logic          mem_read, mem_write, addr_sel;
   logic [BW-1:0] beat;

   // DISPATCH is resolved one cycle after FETCH so op_class reflects the new IR.
   assign cur       = (state_q == StDispatch) ? map_class(op_class) : state_q;
   assign active    = (cur == StFetch) || (cur == StLoad) || (cur == StStore);
   assign state_chg = (state_d != cur);
   assign halted    = (cur == StHalted);

   assign bus.mem_read  = mem_read;
   assign bus.mem_write = mem_write;
   assign bus.addr_sel  = addr_sel;
   assign bus.beat      = beat;

   ctl_seq_beatcnt #(
      .BEATS   (BEATS),
      .TIMEOUT (TIMEOUT),
      .BW      (BW)
   ) u_beatcnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .active      (active),
      .done        (bus.mem_complete),
      .clr         (clr),
      .state_chg   (state_chg),
      .beat        (beat),
      .last_beat   (last_beat),
      .timeout_hit (timeout_hit)
   );

   always_comb begin
      state_d     = cur;
      step_pend_d = step_pend_q;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr_sel    = ADDR_PC;
      write_ir    = 1'b0;
      write_rd    = 1'b0;
      rd_sel      = RD_ALU;
      write_csr   = 1'b0;
      write_pc_ne = 1'b0;
      write_pc_ex = 1'b0;
      mem_fault   = 1'b0;
      clr         = 1'b0;

      unique case (cur)
         StFetch: begin
            mem_read = 1'b1;
            write_ir = bus.mem_complete;
            if (bus.mem_complete && last_beat) state_d = StDispatch;
         end
         StExec: begin
            write_pc_ne = 1'b1;
            if (op_class == OpAlu) begin
               write_rd = 1'b1;
            end else if (op_class == OpCsr) begin
               write_rd  = 1'b1;
               rd_sel    = RD_CSR;
               write_csr = 1'b1;
            end
            state_d = StFetch;
         end
         StLoad: begin
            mem_read = 1'b1;
            addr_sel = ADDR_ALU;
            if (bus.mem_complete && last_beat) state_d = StLoadWb;
         end
         StLoadWb: begin
            write_rd    = 1'b1;
            rd_sel      = RD_MEM;
            write_pc_ne = 1'b1;
            state_d     = StFetch;
         end
         StStore: begin
            mem_write = 1'b1;
            addr_sel  = ADDR_ALU;
            if (bus.mem_complete && last_beat) state_d = StStoreDone;
         end
         StStoreDone: begin
            write_pc_ne = 1'b1;
            state_d     = StFetch;
         end
         StHalted: begin
            if (!debug_req) begin
               state_d     = StResuming;
               step_pend_d = step;
            end
         end
         StResuming: begin
            write_pc_ex = 1'b1;
            state_d     = StFetch;
         end
         default: state_d = StFetch;
      endcase

      // Debug entry/exit states are not instruction boundaries.
      if (cur != StHalted && cur != StResuming) begin
         if (trigger) begin
            write_rd  = 1'b0;
            write_csr = 1'b0;
            mem_write = 1'b0;
            state_d   = StHalted;
            clr       = 1'b1;
         end else if (exception) begin
            write_rd    = 1'b0;
            write_csr   = 1'b0;
            mem_write   = 1'b0;
            write_pc_ex = 1'b1;
            state_d     = debug_req ? StHalted : StFetch;
            clr         = 1'b1;
         end else if (timeout_hit) begin
            mem_fault   = 1'b1;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            write_ir    = 1'b0;
            write_rd    = 1'b0;
            write_csr   = 1'b0;
            write_pc_ex = 1'b1;
            state_d     = StFetch;
            clr         = 1'b1;
         end else if (state_d == StFetch && (debug_req || step_pend_q)) begin
            state_d     = StHalted;
            step_pend_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StFetch;
         step_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_pend_q <= step_pend_d;
      end
   end

endmodule

// File: tb/tb_control_seq.sv
// Directed bench: dut_a (BEATS=1, TIMEOUT=8) and dut_b (BEATS=4, no timeout)
// share clock, reset and decode/debug inputs; each has its own bus bundle.
module tb_control_seq;
   import ctl_seq_pkg::*;

   logic      clk = 1'b0;
   logic      rst_n;
   op_class_t op_class;
   logic      exception, debug_req, step, trigger;

   logic       a_write_ir, a_write_rd, a_write_csr, a_write_pc_ne, a_write_pc_ex;
   logic       a_halted, a_mem_fault;
   logic [1:0] a_rd_sel;
   logic       b_write_ir, b_write_rd, b_write_csr, b_write_pc_ne, b_write_pc_ex;
   logic       b_halted, b_mem_fault;
   logic [1:0] b_rd_sel;

   int tests_run    = 0;
   int tests_failed = 0;

   ctl_seq_if #(.BW(1)) bus_a ();
   ctl_seq_if #(.BW(2)) bus_b ();

   always #5 clk = ~clk;

   control_seq #(.BEATS(1), .TIMEOUT(8)) dut_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_a.master),
      .op_class    (op_class),
      .exception   (exception),
      .debug_req   (debug_req),
      .step        (step),
      .trigger     (trigger),
      .write_ir    (a_write_ir),
      .write_rd    (a_write_rd),
      .rd_sel      (a_rd_sel),
      .write_csr   (a_write_csr),
      .write_pc_ne (a_write_pc_ne),
      .write_pc_ex (a_write_pc_ex),
      .halted      (a_halted),
      .mem_fault   (a_mem_fault)
   );

   control_seq #(.BEATS(4), .TIMEOUT(0)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_b.master),
      .op_class    (op_class),
      .exception   (exception),
      .debug_req   (debug_req),
      .step        (step),
      .trigger     (trigger),
      .write_ir    (b_write_ir),
      .write_rd    (b_write_rd),
      .rd_sel      (b_rd_sel),
      .write_csr   (b_write_csr),
      .write_pc_ne (b_write_pc_ne),
      .write_pc_ex (b_write_pc_ex),
      .halted      (b_halted),
      .mem_fault   (b_mem_fault)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      op_class           = OpAlu;
      exception          = 1'b0;
      debug_req          = 1'b0;
      step               = 1'b0;
      trigger            = 1'b0;
      bus_a.mem_complete = 1'b0;
      bus_b.mem_complete = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [9:0] a_rest;
      logic [10:0] b_rest;
      rst_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      a_rest = {bus_a.mem_write, a_write_ir, a_write_rd, a_rd_sel, a_write_csr, a_write_pc_ne,
                a_write_pc_ex, a_halted, a_mem_fault};
      b_rest = {bus_b.mem_write, b_write_ir, b_write_rd, b_rd_sel, b_write_csr, b_write_pc_ne,
                b_write_pc_ex, b_halted, b_mem_fault};
      tests_run++;
      if ({bus_a.mem_read, bus_a.addr_sel, bus_a.beat} !== 3'b100) begin
         tests_failed++;
         $display("FAIL reset_a_bus: got %b expected 100",
                  {bus_a.mem_read, bus_a.addr_sel, bus_a.beat});
      end
      tests_run++;
      if (a_rest !== 10'd0) begin
         tests_failed++;
         $display("FAIL reset_a_others: got %b expected 0", a_rest);
      end
      tests_run++;
      if ({bus_b.mem_read, bus_b.addr_sel, bus_b.beat} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL reset_b_bus: got %b expected 1000",
                  {bus_b.mem_read, bus_b.addr_sel, bus_b.beat});
      end
      tests_run++;
      if (b_rest !== 11'd0) begin
         tests_failed++;
         $display("FAIL reset_b_others: got %b expected 0", b_rest);
      end
   endtask

   // FETCH/EXEC alternate; bits {mem_read, write_ir, write_rd, rd_sel, write_pc_ne}.
   task automatic test_alu();
      logic [5:0] got, exp;
      apply_reset();
      op_class           = OpAlu;
      bus_a.mem_complete = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         got = {bus_a.mem_read, a_write_ir, a_write_rd, a_rd_sel, a_write_pc_ne};
         exp = (k % 2 == 0) ? 6'b110000 : 6'b001001;
         tests_run++;
         if (got !== exp) begin
            tests_failed++;
            $display("FAIL alu_cycle%0d: got %b expected %b", k, got, exp);
         end
         next_cycle();
      end
   endtask

   // EXEC strobes {write_rd, rd_sel, write_csr, write_pc_ne} for NOWB and CSR.
   task automatic test_classes();
      op_class_t  cls [2] = '{OpNowb, OpCsr};
      logic [4:0] exp [2] = '{5'b00001, 5'b11011};
      logic [4:0] got;
      for (int i = 0; i < 2; i++) begin
         apply_reset();
         op_class           = cls[i];
         bus_a.mem_complete = 1'b1;
         next_cycle();
         @(negedge clk);
         got = {a_write_rd, a_rd_sel, a_write_csr, a_write_pc_ne};
         tests_run++;
         if (got !== exp[i]) begin
            tests_failed++;
            $display("FAIL class_%0d_exec: got %b expected %b", i, got, exp[i]);
         end
      end
   endtask

   // Four-beat fetch then four-beat load with completion every other cycle.
   task automatic test_multibeat();
      int         exp_beat [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
      int         ir_count = 0;
      int         rd_count = 0;
      logic [3:0] got, exp;
      apply_reset();
      op_class = OpLoad;
      for (int c = 0; c < 17; c++) begin
         bus_b.mem_complete = (c % 2 == 1);
         @(negedge clk);
         if (b_write_ir) ir_count++;
         if (b_write_rd) rd_count++;
         if (c < 16) begin
            got = {bus_b.mem_read, bus_b.addr_sel, bus_b.beat};
            exp = {1'b1, (c >= 8), 2'(exp_beat[c])};
            tests_run++;
            if (got !== exp) begin
               tests_failed++;
               $display("FAIL multibeat_c%0d: got %b expected %b", c, got, exp);
            end
         end else begin
            tests_run++;
            if ({b_write_rd, b_rd_sel, b_write_pc_ne} !== {1'b1, RD_MEM, 1'b1}) begin
               tests_failed++;
               $display("FAIL multibeat_wb: got %b expected 1011",
                        {b_write_rd, b_rd_sel, b_write_pc_ne});
            end
         end
         next_cycle();
      end
      tests_run++;
      if (ir_count !== 4) begin
         tests_failed++;
         $display("FAIL multibeat_ir_count: got %0d expected 4", ir_count);
      end
      tests_run++;
      if (rd_count !== 1) begin
         tests_failed++;
         $display("FAIL multibeat_rd_count: got %0d expected 1", rd_count);
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      op_class           = OpStore;
      bus_a.mem_complete = 1'b1;
      next_cycle();
      bus_a.mem_complete = 1'b0;
      for (int w = 0; w < 7; w++) begin
         @(negedge clk);
         tests_run++;
         if ({bus_a.mem_write, a_mem_fault} !== 2'b10) begin
            tests_failed++;
            $display("FAIL timeout_wait%0d: got %b expected 10", w,
                     {bus_a.mem_write, a_mem_fault});
         end
         next_cycle();
      end
      @(negedge clk);
      tests_run++;
      if ({a_mem_fault, bus_a.mem_write, a_write_pc_ex} !== 3'b101) begin
         tests_failed++;
         $display("FAIL timeout_fire: got %b expected 101",
                  {a_mem_fault, bus_a.mem_write, a_write_pc_ex});
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if ({bus_a.mem_read, bus_a.addr_sel, a_mem_fault, a_halted} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL timeout_refetch: got %b expected 1000",
                  {bus_a.mem_read, bus_a.addr_sel, a_mem_fault, a_halted});
      end
      // Completion on the would-be timeout cycle takes precedence.
      repeat (7) next_cycle();
      bus_a.mem_complete = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({a_mem_fault, a_write_ir} !== 2'b01) begin
         tests_failed++;
         $display("FAIL timeout_complete_wins: got %b expected 01", {a_mem_fault, a_write_ir});
      end
   endtask

   task automatic test_debug_step();
      apply_reset();
      op_class           = OpLoad;
      bus_a.mem_complete = 1'b1;
      next_cycle();
      debug_req = 1'b1;
      next_cycle();
      @(negedge clk);
      tests_run++;
      if ({a_write_rd, a_rd_sel, a_halted} !== 4'b1010) begin
         tests_failed++;
         $display("FAIL debug_load_wb: got %b expected 1010", {a_write_rd, a_rd_sel, a_halted});
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if ({a_halted, bus_a.mem_read, a_write_pc_ex} !== 3'b100) begin
         tests_failed++;
         $display("FAIL debug_halted: got %b expected 100",
                  {a_halted, bus_a.mem_read, a_write_pc_ex});
      end
      next_cycle();
      next_cycle();
      debug_req = 1'b0;
      step      = 1'b1;
      next_cycle();
      step = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({a_halted, a_write_pc_ex, bus_a.mem_read} !== 3'b010) begin
         tests_failed++;
         $display("FAIL debug_resuming: got %b expected 010",
                  {a_halted, a_write_pc_ex, bus_a.mem_read});
      end
      next_cycle();
      next_cycle();
      next_cycle();
      @(negedge clk);
      tests_run++;
      if ({a_write_rd, a_halted} !== 2'b10) begin
         tests_failed++;
         $display("FAIL step_load_wb: got %b expected 10", {a_write_rd, a_halted});
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (a_halted !== 1'b1) begin
         tests_failed++;
         $display("FAIL step_rehalt: got %b expected 1", a_halted);
      end
      repeat (5) next_cycle();
      @(negedge clk);
      tests_run++;
      if ({a_halted, bus_a.mem_read} !== 2'b01) begin
         tests_failed++;
         $display("FAIL step_free_run: got %b expected 01", {a_halted, bus_a.mem_read});
      end
   endtask

   task automatic test_trigger_exception();
      apply_reset();
      op_class           = OpAlu;
      bus_a.mem_complete = 1'b1;
      next_cycle();
      trigger   = 1'b1;
      exception = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({a_write_rd, a_write_csr} !== 2'b00) begin
         tests_failed++;
         $display("FAIL trig_exc_suppress: got %b expected 00", {a_write_rd, a_write_csr});
      end
      next_cycle();
      trigger   = 1'b0;
      exception = 1'b0;
      @(negedge clk);
      tests_run++;
      if (a_halted !== 1'b1) begin
         tests_failed++;
         $display("FAIL trig_exc_halt: got %b expected 1", a_halted);
      end
   endtask

   task automatic test_exception();
      apply_reset();
      op_class           = OpAlu;
      bus_a.mem_complete = 1'b1;
      next_cycle();
      exception = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({a_write_rd, a_write_pc_ex} !== 2'b01) begin
         tests_failed++;
         $display("FAIL exc_strobes: got %b expected 01", {a_write_rd, a_write_pc_ex});
      end
      next_cycle();
      exception = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({a_halted, bus_a.mem_read} !== 2'b01) begin
         tests_failed++;
         $display("FAIL exc_refetch: got %b expected 01", {a_halted, bus_a.mem_read});
      end
   endtask

   task automatic test_reset_mid_fetch();
      apply_reset();
      op_class           = OpAlu;
      bus_b.mem_complete = 1'b1;
      next_cycle();
      next_cycle();
      bus_b.mem_complete = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus_b.beat !== 2'd2) begin
         tests_failed++;
         $display("FAIL midreset_pre_beat: got %0d expected 2", bus_b.beat);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus_b.beat, bus_b.mem_read, bus_b.addr_sel} !== 4'b0010) begin
         tests_failed++;
         $display("FAIL midreset_state: got %b expected 0010",
                  {bus_b.beat, bus_b.mem_read, bus_b.addr_sel});
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_classes();
      test_multibeat();
      test_timeout();
      test_debug_step();
      test_trigger_exception();
      test_exception();
      test_reset_mid_fetch();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
